flags_ctrl: RTL and testbench

FLAGS_CTRL -- requirements
Module: flags_ctrl

---
 rtl/flags_ctrl_if.sv | 27 ++
 rtl/flags_ctrl.sv | 88 ++++++++
 tb/tb_flags_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/flags_ctrl_if.sv
// flags_ctrl_if: request/status bundle between the core and the flag controller
interface flags_ctrl_if #(parameter int DEPTH = 4);
   localparam int DW = $clog2(DEPTH + 1);
   logic          alu_we;
   logic [3:0]    alu_flags;
   logic          msr_we;
   logic [3:0]    msr_flags;
   logic          push;
   logic          pop;
   logic [3:0]    cond;
   logic          err_clr;
   logic [3:0]    currentflags;
   logic          condpass;
   logic          busy;
   logic [DW-1:0] depth;
   logic          full;
   logic          empty;
   logic          err;
   modport master (
      output alu_we, alu_flags, msr_we, msr_flags, push, pop, cond, err_clr,
      input  currentflags, condpass, busy, depth, full, empty, err
   );
   modport slave (
      input  alu_we, alu_flags, msr_we, msr_flags, push, pop, cond, err_clr,
      output currentflags, condpass, busy, depth, full, empty, err
   );
endinterface

// File: rtl/flags_ctrl.sv
// flags_ctrl: NZCV flag register with interrupt save stack and condition evaluation
module flags_ctrl #(parameter int DEPTH = 4) (
   input  logic       clk,
   input  logic       reset,
   flags_ctrl_if.slave bus
);
   localparam int DW = $clog2(DEPTH + 1);
   localparam int SN = 2 ** DW;
   typedef enum logic {IDLE, RESTORE} state_t;
   state_t        state_q, state_d;
   logic [3:0]    flags_q, flags_d;
   logic [DW-1:0] depth_q, depth_d;
   logic          err_q, err_d;
   logic [3:0]    stack_q [SN];
   logic [3:0]    stack_d [SN];
   logic          full, empty, pop_ok, pop_err, push_ok, push_err, cp;
   assign full     = depth_q == DW'(DEPTH);
   assign empty    = depth_q == '0;
   assign pop_ok   = bus.pop && !empty;
   assign pop_err  = bus.pop && empty;
   assign push_ok  = bus.push && !bus.pop && !full;
   assign push_err = bus.push && !bus.pop && full;
   always_comb begin
      state_d = state_q;
      flags_d = flags_q;
      depth_d = depth_q;
      err_d   = err_q;
      stack_d = stack_q;
      if (state_q == RESTORE) begin
         flags_d = stack_q[depth_q];
         state_d = IDLE;
      end else if (pop_ok) begin
         depth_d = depth_q - 1'b1;
         state_d = RESTORE;
      end else begin
         if (push_ok) begin
            stack_d[depth_q] = flags_q;
            depth_d          = depth_q + 1'b1;
         end
         flags_d = bus.msr_we ? bus.msr_flags : bus.alu_we ? bus.alu_flags : flags_q;
      end
      // requests, including err_clr, are not honoured while a restore completes
      if (state_q == IDLE)
         err_d = (pop_err || push_err) ? 1'b1 : bus.err_clr ? 1'b0 : err_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         flags_q <= '0;
         depth_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
         depth_q <= depth_d;
         err_q   <= err_d;
      end
   end
   always_ff @(posedge clk) stack_q <= stack_d;
   always_comb begin
      cp = 1'b0;
      case (bus.cond)
         4'h0: cp = flags_q[2];
         4'h1: cp = !flags_q[2];
         4'h2: cp = flags_q[1];
         4'h3: cp = !flags_q[1];
         4'h4: cp = flags_q[3];
         4'h5: cp = !flags_q[3];
         4'h6: cp = flags_q[0];
         4'h7: cp = !flags_q[0];
         4'h8: cp = flags_q[1] && !flags_q[2];
         4'h9: cp = !flags_q[1] || flags_q[2];
         4'hA: cp = flags_q[3] == flags_q[0];
         4'hB: cp = flags_q[3] != flags_q[0];
         4'hC: cp = !flags_q[2] && (flags_q[3] == flags_q[0]);
         4'hD: cp = flags_q[2] || (flags_q[3] != flags_q[0]);
         4'hE: cp = 1'b1;
         default: cp = 1'b0;
      endcase
   end
   assign bus.currentflags = flags_q;
   assign bus.condpass     = cp;
   assign bus.busy         = state_q == RESTORE;
   assign bus.depth        = depth_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.err          = err_q;
endmodule

// File: tb/tb_flags_ctrl.sv
// tb_flags_ctrl: directed scenarios plus random traffic against a queue-based flag model
module tb_flags_ctrl;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   logic [3:0] m_flags;
   logic [3:0] m_stk[$];
   logic [3:0] m_pend;
   bit         m_busy, m_err;
   flags_ctrl_if #(.DEPTH(DEPTH)) bus ();
   flags_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   // ARM-style: each even code has a base test and the following odd code is its inverse
   function automatic bit cond_ref(input logic [3:0] f, input logic [3:0] c);
      bit n = f[3], z = f[2], cy = f[1], v = f[0];
      bit base;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = n == v;
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return base ^ c[0];
   endfunction
   task automatic set_in(input bit aw, input logic [3:0] af, input bit mw, input logic [3:0] mf,
                         input bit pu, input bit po, input bit ec);
      bus.alu_we = aw; bus.alu_flags = af; bus.msr_we = mw; bus.msr_flags = mf;
      bus.push = pu; bus.pop = po; bus.err_clr = ec;
   endtask
   task automatic idle();
      set_in(0, 4'h0, 0, 4'h0, 0, 0, 0);
   endtask
   task automatic model_reset();
      m_flags = 4'h0; m_stk.delete(); m_busy = 0; m_err = 0;
   endtask
   task automatic model_edge();
      if (m_busy) begin
         m_flags = m_pend;
         m_busy  = 0;
      end else begin
         bit perr = bus.pop && m_stk.size() == 0;
         bit uerr = bus.push && !bus.pop && m_stk.size() == DEPTH;
         if (bus.pop && m_stk.size() != 0) begin
            m_pend = m_stk.pop_back();
            m_busy = 1;
         end else begin
            if (bus.push && !bus.pop && m_stk.size() < DEPTH) m_stk.push_back(m_flags);
            if (bus.msr_we) m_flags = bus.msr_flags;
            else if (bus.alu_we) m_flags = bus.alu_flags;
         end
         if (perr || uerr) m_err = 1;
         else if (bus.err_clr) m_err = 0;
      end
   endtask
   task automatic check_all(input string tag);
      check({tag, ".flags"}, 32'(bus.currentflags), 32'(m_flags));
      check({tag, ".depth"}, 32'(bus.depth), 32'(m_stk.size()));
      check({tag, ".full"}, 32'(bus.full), 32'(m_stk.size() == DEPTH));
      check({tag, ".empty"}, 32'(bus.empty), 32'(m_stk.size() == 0));
      check({tag, ".busy"}, 32'(bus.busy), 32'(m_busy));
      check({tag, ".err"}, 32'(bus.err), 32'(m_err));
      check({tag, ".condpass"}, 32'(bus.condpass), 32'(cond_ref(m_flags, bus.cond)));
   endtask
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask
   task automatic pulse_reset(input string tag);
      reset = 1'b1;
      #2;
      model_reset();
      check_all(tag);
      reset = 1'b0;
   endtask
   initial begin
      idle();
      bus.cond = 4'h0;
      model_reset();
      #3;
      check_all("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      // alu write then EQ
      set_in(1, 4'b0100, 0, 4'h0, 0, 0, 0); bus.cond = 4'h0;
      step("s032");
      check("s032.cp_eq", 32'(bus.condpass), 32'd1);
      // msr wins over alu
      set_in(1, 4'b0010, 1, 4'b1001, 0, 0, 0);
      step("s033");
      check("s033.flags", 32'(bus.currentflags), 32'h9);
      bus.cond = 4'hA; #1 check("s033.ge", 32'(bus.condpass), 32'd1);
      bus.cond = 4'hB; #1 check("s033.lt", 32'(bus.condpass), 32'd0);
      // every condition code against a few flag values
      for (int f = 0; f < 16; f += 5) begin
         set_in(0, 4'h0, 1, 4'(f), 0, 0, 0);
         step("csetup");
         idle();
         for (int c = 0; c < 16; c++) begin
            bus.cond = 4'(c);
            #1 check($sformatf("cond%0h_f%0h", c, f), 32'(bus.condpass), 32'(cond_ref(4'(f), 4'(c))));
         end
      end
      // push with simultaneous flag write, then restore
      set_in(1, 4'b0110, 0, 4'h0, 0, 0, 0); step("s034a");
      set_in(1, 4'b1000, 0, 4'h0, 1, 0, 0); step("s034b");
      check("s034.depth1", 32'(bus.depth), 32'd1);
      check("s034.newflags", 32'(bus.currentflags), 32'h8);
      set_in(0, 4'h0, 0, 4'h0, 0, 1, 0); step("s034c");
      check("s034.busy", 32'(bus.busy), 32'd1);
      idle(); step("s034d");
      check("s034.restored", 32'(bus.currentflags), 32'h6);
      check("s034.depth0", 32'(bus.depth), 32'd0);
      check("s034.notbusy", 32'(bus.busy), 32'd0);
      // fill, overflow, clear
      for (int i = 0; i < DEPTH; i++) begin
         set_in(1, 4'(i + 3), 0, 4'h0, 1, 0, 0); step("s035fill");
      end
      check("s035.full", 32'(bus.full), 32'd1);
      set_in(1, 4'hF, 0, 4'h0, 1, 0, 0); step("s035ovf");
      check("s035.depth", 32'(bus.depth), 32'(DEPTH));
      check("s035.err", 32'(bus.err), 32'd1);
      check("s035.flagwrite", 32'(bus.currentflags), 32'hF);
      set_in(0, 4'h0, 0, 4'h0, 0, 0, 1); step("s035clr");
      check("s035.errclr", 32'(bus.err), 32'd0);
      // push+pop together: pop wins, no error
      set_in(0, 4'h0, 0, 4'h0, 1, 1, 0); step("s024a");
      idle(); step("s024b");
      // underflow and reset during restore
      pulse_reset("s036rst");
      set_in(0, 4'h0, 0, 4'h0, 0, 1, 0); step("s036uf");
      check("s036.err", 32'(bus.err), 32'd1);
      check("s036.busy", 32'(bus.busy), 32'd0);
      set_in(1, 4'h5, 0, 4'h0, 1, 0, 0); step("s036push");
      set_in(0, 4'h0, 0, 4'h0, 0, 1, 0); step("s036pop");
      check("s036.inrestore", 32'(bus.busy), 32'd1);
      idle();
      pulse_reset("s036abort");
      step("s036after");
      check("s036.flags0", 32'(bus.currentflags), 32'd0);
      check("s036.depth0", 32'(bus.depth), 32'd0);
      // random traffic
      for (int n = 0; n < 1500; n++) begin
         set_in($urandom_range(0, 9) < 4, 4'($urandom), $urandom_range(0, 9) < 2, 4'($urandom),
                $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1);
         bus.cond = 4'($urandom);
         if ($urandom_range(0, 99) == 0) pulse_reset("rnd_rst");
         step("rnd");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
